data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 24 ++
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Core-to-data-memory access bus: request fields from the execute stage,
// completion/result fields back from the controller.
interface data_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        misaligned;

    modport master (
        output req, we, size, unsigned_ld, addr, wdata,
        input  rdata, stall, done, misaligned
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata,
        output rdata, stall, done, misaligned
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: IDLE->WAIT->DONE, done at accept+WAIT_CYCLES+1 (accept+1 if misaligned).
// Holds the core via stall while a request is presented in IDLE or the access is waiting.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [AW-1:0]   r_idx;
    logic [1:0]      r_lane;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_done;
    logic            r_mis;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_bad;
    logic            w_commit;
    logic [31:0]     w_rd_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;
    logic [3:0]      w_be;
    logic [31:0]     w_wlane;
    logic            w_unused_addr;

    // Address bits above the array index wrap and are deliberately ignored.
    assign w_unused_addr = ^bus.addr[31:AW+2];

    always_comb begin
        w_bad = 1'b0;
        case (bus.size)
            2'b00:   w_bad = 1'b0;
            2'b01:   w_bad = bus.addr[0];
            2'b10:   w_bad = (bus.addr[1:0] != 2'b00);
            default: w_bad = 1'b1;
        endcase
    end

    assign w_commit  = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_rd_word = r_mem[r_idx];
    assign w_byte    = w_rd_word[{r_lane, 3'b000} +: 8];
    assign w_half    = w_rd_word[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load = w_rd_word;
        case (r_size)
            2'b00:   w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_rd_word;
        endcase
    end

    // Store data is right-aligned; replicate it across lanes and let the byte mask pick.
    always_comb begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_lane;
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_lane[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
        endcase
    end

    // Array contents survive reset; only the in-flight store is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_done  <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_size  <= bus.size;
                        r_uns   <= bus.unsigned_ld;
                        r_idx   <= bus.addr[AW+1:2];
                        r_lane  <= bus.addr[1:0];
                        r_wdata <= bus.wdata;
                        if (w_bad) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_mis   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_mis   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.stall      = ((r_state == ST_IDLE) && bus.req) || (r_state == ST_WAIT);
    assign bus.rdata      = r_rdata;
    assign bus.done       = r_done;
    assign bus.misaligned = r_mis;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever done is seen.
module tb_data_mem_ctrl;
    localparam int WC = 2;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = 32'd0;
    exp_t        q[$];

    data_mem_ctrl_if bus();

    data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h want=0x%08h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got=1 want=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_rdata"}, bus.rdata, e.rd);
                chk({e.name, "_mis"}, 32'(bus.misaligned), 32'(e.mis));
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, "_stall_in_done"}, 32'(bus.stall), 32'd0);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want=0 at cycle %0d", q.size(), cyc);
            q.delete();
        end
    endtask

    task automatic push(input string n, input logic [31:0] rd, input logic mis, input int c);
        exp_t e;
        e.rd = rd; e.mis = mis; e.cyc = c; e.name = n;
        q.push_back(e);
    endtask

    task automatic access(input string n, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_load, input logic em);
        logic [31:0] rd;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.unsigned_ld = u;
        bus.addr = a; bus.wdata = d;
        rd = em ? 32'd0 : (w ? last_rd : exp_load);
        last_rd = rd;
        push(n, rd, em, cyc + (em ? 1 : WC + 1));
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; only latched values may matter.
        bus.req = 1'b0; bus.we = ~w; bus.size = 2'($urandom); bus.unsigned_ld = ~u;
        bus.addr = $urandom; bus.wdata = $urandom;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        int c;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.unsigned_ld = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mis", 32'(bus.misaligned), 32'd0);
        chk("rst_stall_noreq", 32'(bus.stall), 32'd0);
        bus.req = 1'b1;
        @(negedge clk);
        chk("rst_prio_stall", 32'(bus.stall), 32'd1);
        chk("rst_prio_done", 32'(bus.done), 32'd0);
        bus.req = 1'b0;
        rst = 1'b0;

        access("st_w10",    1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0);
        access("ld_w10",    0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0);
        access("st_w10z",   1, 2'b10, 0, 32'h10,   32'h0,        32'h0,        0);
        access("st_b13",    1, 2'b00, 0, 32'h13,   32'hAAAAAA80, 32'h0,        0);
        access("ld_b13s",   0, 2'b00, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0);
        access("ld_b13u",   0, 2'b00, 1, 32'h13,   32'h0,        32'h00000080, 0);
        access("ld_w10b",   0, 2'b10, 0, 32'h10,   32'h0,        32'h80000000, 0);
        access("st_w20",    1, 2'b10, 0, 32'h20,   32'h11223344, 32'h0,        0);
        access("ld_h21mis", 0, 2'b01, 0, 32'h21,   32'h0,        32'h0,        1);
        access("st_w22mis", 1, 2'b10, 0, 32'h22,   32'hFFFFFFFF, 32'h0,        1);
        access("ld_w20",    0, 2'b10, 0, 32'h20,   32'h0,        32'h11223344, 0);
        access("ld_sz11",   0, 2'b11, 0, 32'h20,   32'h0,        32'h0,        1);
        access("st_h22",    1, 2'b01, 0, 32'h22,   32'hFFFFBEEF, 32'h0,        0);
        access("ld_h22s",   0, 2'b01, 0, 32'h22,   32'h0,        32'hFFFFBEEF, 0);
        access("ld_h20u",   0, 2'b01, 1, 32'h20,   32'h0,        32'h00003344, 0);
        access("ld_b21s",   0, 2'b00, 0, 32'h21,   32'h0,        32'h00000033, 0);
        access("ld_b23u",   0, 2'b00, 1, 32'h23,   32'h0,        32'h000000BE, 0);
        access("ld_w20b",   0, 2'b10, 0, 32'h20,   32'h0,        32'hBEEF3344, 0);
        access("st_wrap",   1, 2'b10, 0, 32'h1000, 32'hCAFEF00D, 32'h0,        0);
        access("ld_w0",     0, 2'b10, 0, 32'h0,    32'h0,        32'hCAFEF00D, 0);
        access("ld_w10u",   0, 2'b10, 1, 32'h10,   32'h0,        32'h80000000, 0);
        access("prime40",   1, 2'b10, 0, 32'h40,   32'h0BADF00D, 32'h0,        0);

        // Store aborted by reset in its first wait cycle.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 32'h40; bus.wdata = 32'h12345678;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_stall", 32'(bus.stall), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_rdata", bus.rdata, 32'd0);
        chk("abort_mis", 32'(bus.misaligned), 32'd0);
        rst = 1'b0;
        last_rd = 32'd0;
        repeat (5) @(negedge clk);
        access("ld_w40", 0, 2'b10, 0, 32'h40, 32'h0, 32'h0BADF00D, 0);

        // Request held through DONE: second acceptance only in the next IDLE cycle.
        @(negedge clk);
        c = cyc;
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.unsigned_ld = 1'b0; bus.addr = 32'h10;
        push("held_first", 32'h80000000, 1'b0, c + WC + 1);
        push("held_second", 32'h80000000, 1'b0, c + WC + 2 + WC + 1);
        repeat (WC + 2) @(negedge clk);
        chk("held_stall_idle", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1 bus.req = 1'b0;
        drain();
        last_rd = 32'h80000000;

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
